// File: rtl/conv_window_gen_pkg.sv
// Shared 3x3 kernel geometry and window slot numbering.
// The convolution unit imports the same package.
package conv_window_gen_pkg;

    localparam int KERNEL_SIZE = 3;
    localparam int WIN_PIXELS  = KERNEL_SIZE * KERNEL_SIZE;

    // Row-major slot index: k = 3*ky + kx, so k=0 is top-left and k=8 is bottom-right.
    function automatic int slot_idx(input int ky, input int kx);
        return KERNEL_SIZE * ky + kx;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, 3x3 window stream out.
// master = pixel source / window sink, slave = window generator.
interface conv_window_gen_if
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    logic                               enable;
    logic                               sof;
    logic signed [DATA_WIDTH-1:0]       pixel_in;
    logic                               pixel_valid;
    logic [WIN_PIXELS*DATA_WIDTH-1:0]   window_out;
    logic                               valid_out;
    logic [ROW_W-1:0]                   out_row;
    logic [COL_W-1:0]                   out_col;
    logic                               frame_done;

    modport master (
        output enable, sof, pixel_in, pixel_valid,
        input  window_out, valid_out, out_row, out_col, frame_done
    );

    modport slave (
        input  enable, sof, pixel_in, pixel_valid,
        output window_out, valid_out, out_row, out_col, frame_done
    );

endinterface

// File: rtl/conv_line_buffer.sv
// DEPTH-deep delay line with shift enable; the output is the sample
// shifted in DEPTH enabled cycles ago. No reset: contents are gated downstream.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 28
) (
    input  logic                  clk,
    input  logic                  shift_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] taps_q [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            taps_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign data_o = taps_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one registered
// row-major window per valid (unpadded) output position out.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_window_gen_if.slave win_if
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    logic                             accept;
    logic                             win_cond;
    logic                             last_px;
    logic [ROW_W-1:0]                 row_q, row_d, cur_row;
    logic [COL_W-1:0]                 col_q, col_d, cur_col;
    logic [DATA_WIDTH-1:0]            line0_out, line1_out;
    logic [DATA_WIDTH-1:0]            new_col [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]            win_q   [WIN_PIXELS];
    logic [DATA_WIDTH-1:0]            win_d   [WIN_PIXELS];
    logic [WIN_PIXELS*DATA_WIDTH-1:0] window_d, window_q;
    logic                             valid_q, frame_done_q;
    logic [ROW_W-1:0]                 out_row_q;
    logic [COL_W-1:0]                 out_col_q;

    assign accept = win_if.enable & win_if.pixel_valid;

    // sof forces the current pixel to (0,0) before any decision is made on it.
    always_comb begin
        cur_row  = win_if.sof ? '0 : row_q;
        cur_col  = win_if.sof ? '0 : col_q;
        win_cond = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        last_px  = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
        row_d    = row_q;
        col_d    = col_q;
        if (accept) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_line0 (
        .clk        (clk),
        .shift_en_i (accept),
        .data_i     (win_if.pixel_in),
        .data_o     (line0_out)
    );

    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_line1 (
        .clk        (clk),
        .shift_en_i (accept),
        .data_i     (line0_out),
        .data_o     (line1_out)
    );

    // Window after this pixel: columns shift left, new right column enters.
    always_comb begin
        new_col[0] = line1_out;
        new_col[1] = line0_out;
        new_col[2] = win_if.pixel_in;
        for (int k = 0; k < WIN_PIXELS; k++) begin
            win_d[k] = win_q[k];
        end
        for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
            for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                if (kx == KERNEL_SIZE - 1) begin
                    win_d[slot_idx(ky, kx)] = new_col[ky];
                end else begin
                    win_d[slot_idx(ky, kx)] = win_q[slot_idx(ky, kx + 1)];
                end
            end
        end
    end

    for (genvar gi = 0; gi < WIN_PIXELS; gi++) begin : g_pack
        assign window_d[gi*DATA_WIDTH +: DATA_WIDTH] = win_d[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            col_q        <= '0;
            window_q     <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            for (int k = 0; k < WIN_PIXELS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            valid_q      <= win_cond;
            frame_done_q <= win_cond && last_px;
            if (accept) begin
                for (int k = 0; k < WIN_PIXELS; k++) begin
                    win_q[k] <= win_d[k];
                end
            end
            if (win_cond) begin
                window_q  <= window_d;
                out_row_q <= cur_row - ROW_W'(2);
                out_col_q <= cur_col - COL_W'(2);
            end
        end
    end

    assign win_if.window_out = window_q;
    assign win_if.valid_out  = valid_q;
    assign win_if.frame_done = frame_done_q;
    assign win_if.out_row    = out_row_q;
    assign win_if.out_col    = out_col_q;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming 3x3 window generator placed directly upstream of the 3x3 convolution unit. Accepts one signed pixel per cycle in raster order and buffers the two previous image rows. Emits a complete 3x3 neighbourhood, row-major, for every valid (no-padding) output position. Output feeds the convolution unit's window, valid and enable inputs unchanged.

Parameters:
DATA_WIDTH, 8, pixel width (signed, passed through unmodified)
IMG_W, 28, image width in pixels (≥3)
IMG_H, 28, image height in pixels (≥3)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  stage enable; low = stall, no pixel accepted, state held
sof  input  1  start of frame; qualified by pixel_valid; marks pixel as (0,0)
pixel_in  input  DATA_WIDTH  signed input pixel
pixel_valid  input  1  pixel_in valid this cycle
window_out  output  9*DATA_WIDTH  3x3 window; slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]; k=0 top-left, k=8 bottom-right, row-major
valid_out  output  1  window_out valid (one-cycle pulse per window)
out_row  output  clog2(IMG_H)  output-map row of window_out (0..IMG_H-3)
out_col  output  clog2(IMG_W)  output-map column of window_out (0..IMG_W-3)
frame_done  output  1  pulses with the last window of a frame

Behaviour:
- Accept: a pixel is accepted iff enable && pixel_valid. Nothing else advances state.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the accepted pixel. col wraps to 0 after IMG_W-1 and row increments. row wraps to 0 after (IMG_H-1, IMG_W-1). Next frame then starts automatically.
- sof on an accepted pixel: that pixel is (0,0) regardless of counter state. Counters continue from there. sof without acceptance is ignored.
- Line buffers: two IMG_W-deep delay lines. line0 holds row r-1 and line1 holds row r-2, both indexed by column. Each accepted pixel shifts through; no read-before-write hazard within one cycle.
- Window shift register: 3x3 registers. On accept, columns shift left. The new right column is (line1[c], line0[c], pixel_in) as (top, mid, bottom).
- Window condition: the accepted pixel at (r,c) with r≥2, c≥2 completes window rows r-2..r, cols c-2..c. slot0 = P(r-2,c-2) and slot8 = P(r,c).
- Latency: 1 cycle. On the cycle after accept:
  - window_out equals the window above;
  - valid_out=1;
  - out_row=r-2, out_col=c-2;
  - frame_done=1 iff r=IMG_H-1 and c=IMG_W-1.
- No windows for c<2 or r<2. Row-wrap artefacts (columns from the previous row) must never be flagged valid.
- valid_out and frame_done are 0 in every cycle not following a window-completing accept, including all enable-low cycles. window_out, out_row and out_col hold their last value.
- Windows per frame: (IMG_H-2)*(IMG_W-2).
- Reset (async, any time incl. mid-frame): window_out=0, valid_out=0, out_row=0, out_col=0, frame_done=0, row=col=0, window registers=0. Line-buffer storage need not be cleared; correctness is guaranteed by the counter gating. After reset, the first accepted pixel is (0,0).
- No arithmetic; pixel values pass bit-exact.

Decomposition:
- Shared package: KERNEL_SIZE=3, WIN_PIXELS=9, and the window slot-index convention (k = 3*ky + kx). The same package is used by the convolution unit.
- Sub-module: conv_line_buffer. It is a parameterised DATA_WIDTH x IMG_W delay line with shift enable, instantiated twice and inferable as shift register or RAM.

Test Plan:
1. Ramp frame: IMG_W=IMG_H=5, pixel = 5r+c, pixel_valid every cycle. First valid_out comes 1 cycle after pixel 12, with window 0,1,2,5,6,7,10,11,12 and out_row=0, out_col=0. Exactly 9 windows; the last is 12,13,14,17,18,19,22,23,24 with frame_done=1.
2. Row wrap: same frame. Assert no valid_out after pixels 15 or 16 (c<2). The window after pixel 17 is 5,6,7,10,11,12,15,16,17 with out_row=1, out_col=0.
3. Stalls/bubbles: random enable=0 and pixel_valid=0 gaps inserted into test 1. Window contents, order and count are identical. valid_out is never high in cycles following a non-accept.
4. Signed data: all pixels -128 (0x80). Every window slot is 0x80; the 9*8 bus is 0x808080808080808080.
5. sof resync: after 7 pixels of a frame, sof with pixel 0 restarts the frame. The next 25 ramp pixels reproduce test 1 exactly.
6. Reset mid-frame: rst_n low after pixel 14. All outputs go to 0 immediately (asynchronously). After release, a fresh ramp frame reproduces test 1 exactly, back-to-back frames continue, and the second frame's first window equals the first frame's.
